// File: rtl/radix2_butterfly_sequencer_pkg.sv
// Shared definitions for the radix-2 butterfly issue sequencer: octrl bit
// positions, FSM state encoding and derived sizing helpers.
package radix2_butterfly_sequencer_pkg;

    // Bit positions inside the 2-bit butterfly control sideband.
    localparam int CTRL_FIRST = 0;
    localparam int CTRL_LAST  = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Cycles to wait after the last issue of a stage. This covers the read
    // latency, the butterfly pipeline and the write-back, so the next stage
    // reads results that have already landed in memory.
    function automatic int drain_cyc(int mem_rd_lat, int pl_depth, int wb_lat);
        return mem_rd_lat + pl_depth + wb_lat;
    endfunction

    // Width of the butterfly index / twiddle index (N/2 entries). It is kept
    // at least 1 bit so that the degenerate FFT_N=1 case stays legal.
    function automatic int k_width(int fft_n);
        return (fft_n > 1) ? fft_n - 1 : 1;
    endfunction

    // Width of the stage index, with the same 1-bit floor.
    function automatic int stage_width(int fft_n);
        return (fft_n > 1) ? $clog2(fft_n) : 1;
    endfunction

endpackage

// File: rtl/radix2_butterfly_sequencer_if.sv
// Read-address and butterfly-sideband bus driven by the sequencer.
//
// Handshake: rdEn is a valid-only strobe with no ready. The memory and the
// twiddle ROM accept every read in the cycle it is presented. Back-pressure
// is applied upstream through the sequencer's stall input, never on this bus.
// oact marks the cycle in which the read data and octrl/oMemAddr line up at
// the butterfly input.
interface radix2_butterfly_sequencer_if #(
    parameter int FFT_N = 10
);
    localparam int KW = radix2_butterfly_sequencer_pkg::k_width(FFT_N);

    logic             rdEn;
    logic [FFT_N-1:0] rdAddrA;
    logic [FFT_N-1:0] rdAddrB;
    logic [KW-1:0]    twAddr;
    logic             oact;
    logic [1:0]       octrl;
    logic [KW-1:0]    oMemAddr;

    modport master (
        output rdEn, rdAddrA, rdAddrB, twAddr, oact, octrl, oMemAddr
    );

    modport slave (
        input rdEn, rdAddrA, rdAddrB, twAddr, oact, octrl, oMemAddr
    );

endinterface

// File: rtl/radix2_butterfly_sequencer_sideband.sv
// Fixed-depth register chain that carries {act, ctrl, addr} alongside the
// memory read, so the sideband reaches the butterfly with the read data.
// The chain advances every cycle. An idle or stalled slot simply carries
// act=0.
module r2_sideband_delay #(
    parameter int DEPTH = 1,
    parameter int AW    = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_act,
    input  logic [1:0]    in_ctrl,
    input  logic [AW-1:0] in_addr,
    output logic          out_act,
    output logic [1:0]    out_ctrl,
    output logic [AW-1:0] out_addr
);
    localparam int W = 1 + 2 + AW;

    logic [W-1:0] pipe_d [DEPTH];
    logic [W-1:0] pipe_q [DEPTH];

    // Shift: the new sample enters slot 0 and each slot takes its predecessor.
    always_comb begin
        pipe_d[0] = {in_act, in_ctrl, in_addr};
        for (int i = 1; i < DEPTH; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // Chain registers; an asynchronous clear flushes every slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign {out_act, out_ctrl, out_addr} = pipe_q[DEPTH-1];

endmodule

// File: rtl/radix2_butterfly_sequencer.sv
// Radix-2 DIF butterfly issue sequencer. It walks FFT_N stages and issues
// N/2 operand-pair reads per stage, together with twiddle ROM addresses and
// the butterfly sideband. Between stages it waits for the pipeline and the
// write-back to drain.
module radix2_butterfly_sequencer
    import radix2_butterfly_sequencer_pkg::*;
#(
    parameter int FFT_N      = 10,
    parameter int PL_DEPTH   = 3,
    parameter int MEM_RD_LAT = 1,
    parameter int WB_LAT     = 1,
    localparam int KW        = k_width(FFT_N),
    localparam int SW        = stage_width(FFT_N)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         stall,
    output logic                         busy,
    output logic                         done,
    output logic [SW-1:0]                stage,
    output state_e                       state_dbg,
    radix2_butterfly_sequencer_if.master bus
);
    localparam int DRAIN_CYC = drain_cyc(MEM_RD_LAT, PL_DEPTH, WB_LAT);
    localparam int CW        = $clog2(DRAIN_CYC + 1);
    localparam logic [KW-1:0] K_LAST = KW'((1 << (FFT_N - 1)) - 1);
    localparam logic [SW-1:0] S_LAST = SW'(FFT_N - 1);

    state_e           state_d, state_q;
    logic [KW-1:0]    k_d, k_q;
    logic [SW-1:0]    stage_d, stage_q;
    logic [CW-1:0]    cnt_d, cnt_q;
    logic             busy_d, busy_q;
    logic             done_d, done_q;
    logic             rd_en_d, rd_en_q;
    logic [1:0]       ctrl_d, ctrl_q;
    logic [FFT_N-1:0] addr_a_d, addr_a_q;
    logic [FFT_N-1:0] addr_b_d, addr_b_q;
    logic [KW-1:0]    tw_d, tw_q;
    logic [KW-1:0]    mem_addr_d, mem_addr_q;

    int               shift;
    logic [FFT_N-1:0] k_ext, span, lo_mask;
    logic [FFT_N-1:0] addr_a_calc, addr_b_calc;
    logic [KW-1:0]    tw_calc;

    // Operand addresses for (stage, k). A is k with a zero inserted at bit
    // FFT_N-1-stage, B is A plus the span, and the twiddle index is the
    // in-group offset scaled by 2^stage.
    always_comb begin
        shift       = FFT_N - 1 - int'(stage_q);
        k_ext       = FFT_N'(k_q);
        span        = FFT_N'(1) << shift;
        lo_mask     = span - FFT_N'(1);
        addr_a_calc = ((k_ext & ~lo_mask) << 1) | (k_ext & lo_mask);
        addr_b_calc = addr_a_calc + span;
        tw_calc     = KW'((k_ext & lo_mask) << stage_q);
    end

    // Next-state logic: IDLE -> ISSUE (N/2 reads) -> DRAIN, repeated per
    // stage, then DONE -> IDLE.
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        stage_d    = stage_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        rd_en_d    = 1'b0;
        ctrl_d     = 2'b00;
        addr_a_d   = addr_a_q;
        addr_b_d   = addr_b_q;
        tw_d       = tw_q;
        mem_addr_d = mem_addr_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ISSUE;
                    k_d     = '0;
                    stage_d = '0;
                    busy_d  = 1'b1;
                end
            end
            ISSUE: begin
                if (!stall) begin
                    rd_en_d            = 1'b1;
                    addr_a_d           = addr_a_calc;
                    addr_b_d           = addr_b_calc;
                    tw_d               = tw_calc;
                    mem_addr_d         = k_q;
                    ctrl_d[CTRL_FIRST] = (k_q == '0);
                    ctrl_d[CTRL_LAST]  = (k_q == K_LAST);
                    if (k_q == K_LAST) begin
                        state_d = DRAIN;
                        k_d     = '0;
                        cnt_d   = CW'(DRAIN_CYC);
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end
            DRAIN: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q <= CW'(1)) begin
                    if (stage_q == S_LAST) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ISSUE;
                        stage_d = stage_q + SW'(1);
                        k_d     = '0;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state and registered outputs; an asynchronous reset aborts any run.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            k_q        <= '0;
            stage_q    <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_en_q    <= 1'b0;
            ctrl_q     <= 2'b00;
            addr_a_q   <= '0;
            addr_b_q   <= '0;
            tw_q       <= '0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            stage_q    <= stage_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_en_q    <= rd_en_d;
            ctrl_q     <= ctrl_d;
            addr_a_q   <= addr_a_d;
            addr_b_q   <= addr_b_d;
            tw_q       <= tw_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    r2_sideband_delay #(
        .DEPTH (MEM_RD_LAT),
        .AW    (KW)
    ) u_sideband (
        .clk      (clk),
        .rst      (rst),
        .in_act   (rd_en_q),
        .in_ctrl  (ctrl_q),
        .in_addr  (mem_addr_q),
        .out_act  (bus.oact),
        .out_ctrl (bus.octrl),
        .out_addr (bus.oMemAddr)
    );

    assign busy        = busy_q;
    assign done        = done_q;
    assign stage       = stage_q;
    assign state_dbg   = state_q;
    assign bus.rdEn    = rd_en_q;
    assign bus.rdAddrA = addr_a_q;
    assign bus.rdAddrB = addr_b_q;
    assign bus.twAddr  = tw_q;

endmodule

// File: doc/radix2_butterfly_sequencer.md
Name: radix2_butterfly_sequencer

Overview:
Initiator side of the radix-2 butterfly datapath. It walks all FFT_N stages of an in-place DIF FFT and drives the memory read addresses for each butterfly operand pair. It also drives the twiddle ROM address, and the act/ctrl/MemAddr sideband that enters the butterfly aligned with the returned read data. Between stages it waits for the butterfly pipeline and write-back to drain, so the next stage never reads stale data.

Parameters:
FFT_N, 10, log2 of transform length N
PL_DEPTH, 3, butterfly pipeline depth in cycles (0..2 used by the butterfly; any value is legal here)
MEM_RD_LAT, 1, data memory and twiddle ROM read latency in cycles, >=1
WB_LAT, 1, cycles from butterfly output to the write being visible in memory

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle request to run a full transform; sampled only in IDLE
stall  in  1  when high, holds issue (memory arbitration back-pressure)
busy  out  1  high from the accepted start until done
done  out  1  one-cycle pulse when the transform completes
rdEn  out  1  memory read strobe for the current operand pair
rdAddrA  out  FFT_N  operand A address
rdAddrB  out  FFT_N  operand B address
twAddr  out  FFT_N-1  twiddle ROM index
stage  out  $clog2(FFT_N)  current stage index, 0..FFT_N-1
oact  out  1  feeds the butterfly iact; rdEn delayed by MEM_RD_LAT
octrl  out  2  feeds the butterfly ictrl: bit0 = first butterfly of stage, bit1 = last butterfly of stage; delayed by MEM_RD_LAT
oMemAddr  out  FFT_N-1  feeds the butterfly iMemAddr: butterfly index k, delayed by MEM_RD_LAT

Behaviour:
- Reset (rst=0, asynchronous) clears all state: IDLE, k=0, stage=0, drain counter 0, delay line cleared. All outputs read 0.
- States:
  - IDLE: start=1 -> ISSUE, stage=0, k=0, busy=1 from the next cycle.
  - ISSUE: each cycle with stall=0, assert rdEn and increment k. Cycles with stall=1 hold rdEn=0 and k unchanged.
  - ISSUE exit: when k=N/2-1 is issued -> DRAIN, loading DRAIN_CYC = MEM_RD_LAT + PL_DEPTH + WB_LAT.
  - DRAIN: decrement the counter. At 1: if stage=FFT_N-1 -> DONE; otherwise stage+1, k=0 -> ISSUE.
  - DONE: done=1 for one cycle, busy=0 on the same edge -> IDLE.
- stall is ignored in DRAIN and DONE. start is ignored while busy.
- Address generation, for stage s and k in 0..N/2-1:
  - span = N>>(s+1).
  - rdAddrA = k with a 0 bit inserted at position FFT_N-1-s.
  - rdAddrB = rdAddrA + span.
  - twAddr = (k & (span-1)) << s, truncated to FFT_N-1 bits.
- octrl at issue time: bit0 = (k==0), bit1 = (k==N/2-1). With N/2=1 both bits are set on the same butterfly.
- Outputs rdAddrA/B, twAddr and rdEn are registered.
- oact/octrl/oMemAddr: a MEM_RD_LAT-deep register chain from rdEn/ctrl/k, so the sideband arrives with the read data. Chain entries advance every cycle, including during stall; a stalled slot carries oact=0.
- Run length with no stall: done asserts on cycle 1 + FFT_N*(N/2 + DRAIN_CYC) after the start-sampling edge.
- Reset mid-run aborts immediately. No done pulse is issued, and the delay line is flushed (oact=0).

Decomposition:
- Shared package: ctrl bit indices (CTRL_FIRST=0, CTRL_LAST=1), state enum (IDLE, ISSUE, DRAIN, DONE), DRAIN_CYC computation function.
- One natural sub-module: r2_sideband_delay, a parameterised-depth register chain for {act, ctrl, addr} with async active-low clear.

Test Plan:
- Address pattern, FFT_N=3, no stall, start pulse:
  - stage0 pairs (0,4)(1,5)(2,6)(3,7), tw 0,1,2,3
  - stage1 pairs (0,2)(1,3)(4,6)(5,7), tw 0,2,0,2
  - stage2 pairs (0,1)(2,3)(4,5)(6,7), tw 0,0,0,0
- Timing, same config with PL_DEPTH=3, MEM_RD_LAT=1, WB_LAT=1: done on cycle 28 after start. busy high cycles 1..27. 5 idle rdEn cycles between stages. octrl=01 on k=0, 10 on k=3, each 1 cycle after rdEn.
- Stall: hold stall=1 for 3 cycles at stage1 k=2 -> rdEn low for 3 cycles, k held at 2, oact gaps match; done delayed by exactly 3 cycles (cycle 31).
- Start ignored: pulse start at cycle 10 of a run -> no restart, single done at cycle 28.
- Reset mid-run: drop rst at cycle 12 -> all outputs 0 asynchronously, no done. A fresh start afterwards reproduces the full stage0 pattern.
- Degenerate FFT_N=1: single butterfly (0,1), tw 0, octrl=11, done after 1+1+DRAIN_CYC cycles.
